i2s_tx: RTL
===========

# i2s_tx

I2S transmitter that carries the effect chain's output sample to the DAC. It accepts one mono signed sample per frame through a valid/ready handshake. It MSB-aligns the sample into a 32-bit slot and sends it serially on both the left and right channels. BCLK and LRCLK are generated internally from CLK. It sits at the end of the chain, after the delay/echo stage output `y`.

## Interface
- `DATA_WIDTH`, 32, width of `sample_in` (two's complement).
- `SAMPLE_BITS`, 24, number of MSBs transmitted per channel; must satisfy 1 ≤ SAMPLE_BITS ≤ min(32, DATA_WIDTH).
- `BCLK_DIV`, 4, CLK cycles per BCLK half-period; must be ≥ 1.

- `CLK`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sample_in`  in  DATA_WIDTH  mono sample; transmitted bits are `sample_in[DATA_WIDTH-1 -: SAMPLE_BITS]`.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  holding register empty; a transfer occurs on a CLK edge where valid && ready.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  I2S word select: 0 = left, 1 = right.
- `sdata`  out  1  I2S serial data.
- `underrun`  out  1  one-CLK pulse when a frame starts with the holding register empty.

## Operation
- **Divider.** `div` counts 0..BCLK_DIV-1. On the cycle where div == BCLK_DIV-1, `bclk` toggles and `div` returns to 0. A falling event is a toggle taken while `bclk` == 1.
- **Frame counter.** `fb` (6 bits, 0..63) advances by 1 modulo 64 on each falling event. All outputs change only on falling events.
- **Slots.** Left slot is fb 0..31; right slot is fb 32..63. Each slot carries 32 bits, MSB first. Slot bit k (k = fb mod 32) equals frame-sample bit SAMPLE_BITS-1-k for k < SAMPLE_BITS, and 0 otherwise.
- **lrclk.** `lrclk` leads data by one BCLK, per the I2S standard: 1 for fb 31..62, 0 for fb 63 and 0..30.
- **Holding register.** Single entry with a full flag; `sample_ready` = !full.
  - valid && ready sets full and captures the transmitted bits.
- **Frame load.** Occurs on the falling event entering fb = 0.
  - If full: the frame register takes the holding register, and full clears.
  - If empty: the frame register keeps its previous value (sample repeats) and `underrun` pulses.
  - The same frame register feeds both channels.
- **Simultaneous accept and load.** When the holding register is empty and a sample is accepted on the load edge, underrun still pulses. The accepted sample fills the holding register and is transmitted in the next frame.
- **Reset values.** bclk=0, lrclk=0, sdata=0, sample_ready=1, underrun=0. Internally: div=0, fb=63, full=0, frame register=0.
- **Reset mid-frame.** Aborts the frame immediately, returns every register to its reset value, and discards any held sample.

## Timing
- After reset release, `bclk` rises at CLK edge BCLK_DIV and falls at edge 2·BCLK_DIV. That falling event is the first frame load (fb=0). With an empty holding register it pulses underrun and sends zeros.
- BCLK period is 2·BCLK_DIV CLK cycles. Frame period is 128·BCLK_DIV CLK cycles (512 at defaults).
- `sdata` and `lrclk` update on the same CLK edge that drives `bclk` low. They are stable for a full BCLK period around the following rising edge.
- `sample_ready` deasserts the cycle after an accept. It reasserts the cycle after the frame load that consumes the held sample.
- The latency from accept to MSB on `sdata` is at most one frame period plus one CLK.

## Test plan
- **Reset.** Hold rst low for 3 cycles, then release.
  - During reset: all outputs 0 except sample_ready=1.
  - After release: bclk rises at edge 4 and falls at edge 8; underrun pulses at edge 8; sdata stays 0 for the whole first frame.
- **Basic frame.** Accept sample_in=0xA5A5A5_00 before the first load.
  - Left slot carries 0xA5A5A5 MSB-first on fb 0..23, then zeros on fb 24..31.
  - Right slot repeats it on fb 32..55.
  - lrclk rises at fb 31 and falls at fb 63.
- **Backpressure.** Drive 0x111111_00 then 0x222222_00 back-to-back with valid held.
  - The first is accepted and ready drops.
  - The second waits with ready low until the next load edge, then is accepted.
  - Frames carry 0x111111 followed by 0x222222.
- **Underrun.** After one sample (0x7FFFFF_00), send nothing more.
  - Next frame repeats 0x7FFFFF.
  - underrun pulses exactly once per starved frame, for one CLK each time.
- **Sign/extremes.** Send 0x800000_00, then 0xFFFFFF_00.
  - First frame: MSB 1 followed by 23 zeros.
  - Second frame: 24 ones, then 8 zeros.
- **Reset mid-frame.** Assert rst at fb=40 while holding full.
  - Outputs return to reset values within the reset cycle (asynchronous).
  - After release, timing restarts as in the reset scenario with sdata=0; the held sample is lost.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: one mono sample per frame, MSB-aligned in a 32-bit slot,
// sent on both channels with internally generated BCLK/LRCLK.
module i2s_tx #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SAMPLE_BITS = 24,
    parameter int unsigned BCLK_DIV    = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int unsigned DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned FB_W   = 6;
    localparam int unsigned SLOT_W = 32;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
    localparam logic [FB_W-1:0]  FB_LAST = FB_W'(63);

    logic [DIV_W-1:0]       div_q, div_d;
    logic                   bclk_q, bclk_d;
    logic [FB_W-1:0]        fb_q, fb_d;
    logic                   full_q, full_d;
    logic [SAMPLE_BITS-1:0] hold_q, hold_d;
    logic [SAMPLE_BITS-1:0] frame_q, frame_d;
    logic                   lrclk_q, lrclk_d;
    logic                   sdata_q, sdata_d;
    logic                   underrun_q, underrun_d;
    logic                   ready_q, ready_d;

    logic                   tick;
    logic                   fall;
    logic                   accept;
    logic [SLOT_W-1:0]      slot_word;
    logic [SLOT_W-1:0]      slot_shift;

    // Divider, frame sequencing, holding register and serializer.
    always_comb begin
        div_d      = div_q;
        bclk_d     = bclk_q;
        fb_d       = fb_q;
        full_d     = full_q;
        hold_d     = hold_q;
        frame_d    = frame_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        slot_word  = '0;
        slot_shift = '0;

        tick   = (div_q == DIV_MAX);
        fall   = tick && bclk_q;
        accept = sample_valid && ready_q;

        if (tick) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (fall) begin
            fb_d = fb_q + FB_W'(1);
            // Frame load happens on the falling event that wraps fb to 0.
            if (fb_q == FB_LAST) begin
                if (full_q) begin
                    frame_d = hold_q;
                    full_d  = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            lrclk_d    = (fb_d >= FB_W'(31)) && (fb_d <= FB_W'(62));
            slot_word  = SLOT_W'(frame_d) << (SLOT_W - SAMPLE_BITS);
            slot_shift = slot_word << fb_d[4:0];
            sdata_d    = slot_shift[SLOT_W-1];
        end

        // Accept only when empty, so it never collides with the load clearing full.
        if (accept) begin
            hold_d = sample_in[DATA_WIDTH-1 -: SAMPLE_BITS];
            full_d = 1'b1;
        end

        ready_d = ~full_d;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            fb_q       <= FB_LAST;
            full_q     <= 1'b0;
            hold_q     <= '0;
            frame_q    <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            fb_q       <= fb_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            frame_q    <= frame_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
        end
    end

    assign sample_ready = ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule
